// File: rtl/alu_seq_exec.sv
// Execution unit for the decoded 4-bit ALU code: single-cycle AND/OR/ADD/SUB and
// an iterative 1-bit-per-cycle SRL, with valid/ready handshakes on both sides.
module alu_seq_exec #(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   shreg_q, shreg_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ill;
    logic [XLEN-1:0]   shifted;

    assign accept  = in_valid && (state_q == IDLE);
    assign shamt   = b[SHW-1:0];
    assign shifted = shreg_q >> 1;

    // Single-cycle result; SRL by zero passes a through.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (operation)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SRL:  alu_res = a;
            default: alu_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((operation == OP_SRL) && (shamt != '0)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((operation == OP_SRL) && (shamt != '0)) begin
                        shreg_d = a;
                        cnt_d   = shamt;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    illegal_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: expected results queued at accept, checked when out_valid rises.
module tb_alu_seq_exec;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];

    alu_seq_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation in the current cycle; returns the accept cycle number.
    task automatic accept(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input exp_t e, output int acc);
        int waited = 0;
        while (!in_ready && waited < 64) begin
            tick();
            waited++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        operation = op;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        acc       = cyc;
        sb.push_back(e);
        tick();
        in_valid  = 1'b0;
        operation = 4'($urandom);
        a         = $urandom;
        b         = $urandom;
    endtask

    // Wait for out_valid, compare against the queue head, hold for `hold` cycles, then drain.
    task automatic collect(input string tag, input int acc, input int hold);
        exp_t e;
        int   lat;
        int   waited = 0;
        while (!out_valid && waited < 64) begin
            check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            tick();
            waited++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        e   = sb.pop_front();
        lat = cyc - acc;
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_result"}, result, e.res);
        check({tag, "_zero"}, 32'(zero), 32'(e.zero));
        check({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            operation = 4'b0010;
            a         = $urandom;
            b         = $urandom;
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_result"}, result, e.res);
            check({tag, "_hold_zero"}, 32'(zero), 32'(e.zero));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] res, input logic zf,
                       input logic ill, input int lat, input int hold);
        int   acc;
        exp_t e;
        e.res  = res;
        e.zero = zf;
        e.ill  = ill;
        e.lat  = 8'(lat);
        accept(op, av, bv, e, acc);
        collect(tag, acc, hold);
    endtask

    initial begin
        int   acc;
        exp_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = 4'b0000;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // out_ready outside DONE must not disturb the idle state
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_ignored", 32'(in_ready), 32'd1);

        run("add_5_7",    4'b0010, 32'd5,         32'd7,          32'd12,         1'b0, 1'b0, 1, 0);
        run("sub_eq",     4'b0110, 32'h1234,      32'h1234,       32'd0,          1'b1, 1'b0, 1, 0);
        run("sub_0_1",    4'b0110, 32'd0,         32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 1, 0);
        run("srl_3",      4'b0101, 32'h8000_0000, 32'h0000_0023,  32'h1000_0000,  1'b0, 1'b0, 4, 0);
        run("srl_0",      4'b0101, 32'h8000_0000, 32'h0000_0000,  32'h8000_0000,  1'b0, 1'b0, 1, 0);
        run("or_bp",      4'b0001, 32'h0000_00F0, 32'h0000_000F,  32'h0000_00FF,  1'b0, 1'b0, 1, 5);
        run("and",        4'b0000, 32'h0000_FF00, 32'h0000_0FF0,  32'h0000_0F00,  1'b0, 1'b0, 1, 0);
        run("add_wrap",   4'b0010, 32'hFFFF_FFFF, 32'd1,          32'd0,          1'b1, 1'b0, 1, 0);
        run("srl_shift_out", 4'b0101, 32'h0000_0001, 32'hFFFF_FFE1, 32'd0,        1'b1, 1'b0, 2, 0);
        run("illegal",    4'b0011, 32'h0000_00AA, 32'h0000_0055,  32'd0,          1'b1, 1'b1, 1, 0);

        // SRL by 31 aborted by reset in the second shift cycle
        e.res  = 32'd1;
        e.zero = 1'b0;
        e.ill  = 1'b0;
        e.lat  = 8'd32;
        accept(4'b0101, 32'h8000_0000, 32'd31, e, acc);
        check("abort_shift1_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("abort_shift2_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_front());
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_illegal", 32'(illegal), 32'd0);

        run("add_1_1",    4'b0010, 32'd1,         32'd1,          32'd2,          1'b0, 1'b0, 1, 0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
